// File: rtl/fft_out_reorder_pkg.sv
// Shared constants, state types and index helpers for the FFT output reorder block.
package fft_out_reorder_pkg;

  localparam int LANES = 4;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_FILL = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  // Ceiling log2, evaluated at elaboration time for widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Reverse the low 'width' bits of k.
  function automatic int bitrev(input int k, input int width);
    int result;
    result = 0;
    for (int i = 0; i < width; i++) begin
      result = result | (((k >> i) & 1) << (width - 1 - i));
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One reorder bank: N words of storage written four lanes at a time in
// bit-reversed positions and read four consecutive natural-order bins at a time.
module fft_reorder_bank
  import fft_out_reorder_pkg::*;
#(
  parameter int DW = 30,
  parameter int N  = 32
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      wr_en,
  input  logic [clog2(N)-3:0]   wr_beat,
  input  logic [DW-1:0]         wr_l0,
  input  logic [DW-1:0]         wr_l1,
  input  logic [DW-1:0]         wr_l2,
  input  logic [DW-1:0]         wr_l3,
  input  logic [clog2(N)-3:0]   rd_beat,
  output logic [DW-1:0]         rd_l0,
  output logic [DW-1:0]         rd_l1,
  output logic [DW-1:0]         rd_l2,
  output logic [DW-1:0]         rd_l3
);

  localparam int LOG2N = clog2(N);

  logic [DW-1:0]    mem     [N];
  logic [DW-1:0]    wr_data [LANES];
  logic [LOG2N-1:0] wr_addr [LANES];

  // Arrival index of lane l on beat c is 4c+l; it lands at its bit-reversed bin.
  always_comb begin
    wr_data[0] = wr_l0;
    wr_data[1] = wr_l1;
    wr_data[2] = wr_l2;
    wr_data[3] = wr_l3;
    for (int l = 0; l < LANES; l++) begin
      wr_addr[l] = LOG2N'(bitrev(LANES * int'(wr_beat) + l, LOG2N));
    end
  end

  // Storage has no reset; contents are only read after a complete fill.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr_en[l]) mem[wr_addr[l]] <= wr_data[l];
    end
  end

  // Read beat r presents bins 4r..4r+3 combinationally.
  always_comb begin
    rd_l0 = mem[{rd_beat, 2'd0}];
    rd_l1 = mem[{rd_beat, 2'd1}];
    rd_l2 = mem[{rd_beat, 2'd2}];
    rd_l3 = mem[{rd_beat, 2'd3}];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder: accepts four bit-reversed lanes per beat, buffers a frame
// in one of two ping-pong banks and drains it in natural bin order with sof framing.
module fft_out_reorder
  import fft_out_reorder_pkg::*;
#(
  parameter int DW = 30,
  parameter int N  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_l0,
  input  logic [DW-1:0] in_l1,
  input  logic [DW-1:0] in_l2,
  input  logic [DW-1:0] in_l3,
  output logic          out_valid,
  output logic          out_sof,
  output logic [DW-1:0] out_l0,
  output logic [DW-1:0] out_l1,
  output logic [DW-1:0] out_l2,
  output logic [DW-1:0] out_l3,
  output logic          frame_err
);

  localparam int LOG2N = clog2(N);
  localparam int CW    = LOG2N - 2;
  localparam int BEATS = N / LANES;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  wr_state_t     wr_state, wr_state_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic          wr_bank, wr_bank_n;
  logic          wr_go;
  logic [CW-1:0] wr_beat;
  logic          frame_done;
  logic          frame_err_n;

  rd_state_t     rd_state, rd_state_n;
  logic [CW-1:0] rcnt, rcnt_n;
  logic          rd_bank, rd_bank_n;
  logic          out_valid_n, out_sof_n;
  logic [DW-1:0] out_l0_n, out_l1_n, out_l2_n, out_l3_n;

  logic [DW-1:0] b0_l0, b0_l1, b0_l2, b0_l3;
  logic [DW-1:0] b1_l0, b1_l1, b1_l2, b1_l3;

  fft_reorder_bank #(.DW(DW), .N(N)) u_bank0 (
    .clk     (clk),
    .wr_en   ({LANES{wr_go && !wr_bank}}),
    .wr_beat (wr_beat),
    .wr_l0   (in_l0),
    .wr_l1   (in_l1),
    .wr_l2   (in_l2),
    .wr_l3   (in_l3),
    .rd_beat (rcnt),
    .rd_l0   (b0_l0),
    .rd_l1   (b0_l1),
    .rd_l2   (b0_l2),
    .rd_l3   (b0_l3)
  );

  fft_reorder_bank #(.DW(DW), .N(N)) u_bank1 (
    .clk     (clk),
    .wr_en   ({LANES{wr_go && wr_bank}}),
    .wr_beat (wr_beat),
    .wr_l0   (in_l0),
    .wr_l1   (in_l1),
    .wr_l2   (in_l2),
    .wr_l3   (in_l3),
    .rd_beat (rcnt),
    .rd_l0   (b1_l0),
    .rd_l1   (b1_l1),
    .rd_l2   (b1_l2),
    .rd_l3   (b1_l3)
  );

  // Write side: start on sof, count beats, restart on a mid-fill sof, hand the bank over when full.
  always_comb begin
    wr_state_n  = wr_state;
    wcnt_n      = wcnt;
    wr_bank_n   = wr_bank;
    wr_go       = 1'b0;
    wr_beat     = wcnt;
    frame_done  = 1'b0;
    frame_err_n = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (in_valid && in_sof) begin
          wr_go      = 1'b1;
          wr_beat    = '0;
          wcnt_n     = CW'(1);
          wr_state_n = WR_FILL;
        end
      end
      WR_FILL: begin
        if (in_valid) begin
          wr_go = 1'b1;
          if (in_sof) begin
            frame_err_n = 1'b1;
            wr_beat     = '0;
            wcnt_n      = CW'(1);
          end else if (wcnt == LAST_BEAT) begin
            frame_done = 1'b1;
            wr_bank_n  = ~wr_bank;
            wcnt_n     = '0;
            wr_state_n = WR_IDLE;
          end else begin
            wcnt_n = wcnt + CW'(1);
          end
        end
      end
    endcase
  end

  // Read side: drain the just-filled bank for N/4 contiguous beats, chaining straight into the next frame.
  always_comb begin
    rd_state_n  = rd_state;
    rcnt_n      = rcnt;
    rd_bank_n   = rd_bank;
    out_valid_n = 1'b0;
    out_sof_n   = 1'b0;
    out_l0_n    = '0;
    out_l1_n    = '0;
    out_l2_n    = '0;
    out_l3_n    = '0;
    case (rd_state)
      RD_IDLE: begin
        if (frame_done) begin
          rd_state_n = RD_DRAIN;
          rcnt_n     = '0;
          rd_bank_n  = wr_bank;
        end
      end
      RD_DRAIN: begin
        out_valid_n = 1'b1;
        out_sof_n   = (rcnt == '0);
        out_l0_n    = rd_bank ? b1_l0 : b0_l0;
        out_l1_n    = rd_bank ? b1_l1 : b0_l1;
        out_l2_n    = rd_bank ? b1_l2 : b0_l2;
        out_l3_n    = rd_bank ? b1_l3 : b0_l3;
        if (rcnt == LAST_BEAT) begin
          rcnt_n = '0;
          if (frame_done) begin
            rd_bank_n = wr_bank;
          end else begin
            rd_state_n = RD_IDLE;
          end
        end else begin
          rcnt_n = rcnt + CW'(1);
        end
      end
    endcase
  end

  // Write FSM state, beat counter and fill-bank select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= WR_IDLE;
      wcnt     <= '0;
      wr_bank  <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      wcnt     <= wcnt_n;
      wr_bank  <= wr_bank_n;
    end
  end

  // Read FSM state, beat counter and drain-bank select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= RD_IDLE;
      rcnt     <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_state <= rd_state_n;
      rcnt     <= rcnt_n;
      rd_bank  <= rd_bank_n;
    end
  end

  // Registered outputs so downstream sees clean, glitch-free framing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_l0    <= '0;
      out_l1    <= '0;
      out_l2    <= '0;
      out_l3    <= '0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= out_valid_n;
      out_sof   <= out_sof_n;
      out_l0    <= out_l0_n;
      out_l1    <= out_l1_n;
      out_l2    <= out_l2_n;
      out_l3    <= out_l3_n;
      frame_err <= frame_err_n;
    end
  end

  // A fill lasts at least N/4 cycles, so a new frame can only complete while the drain issues its final beat.
  hazard_check: assert property (@(posedge clk) disable iff (!rst)
    !(frame_done && (rd_state == RD_DRAIN) && (rcnt != LAST_BEAT)));

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: a frame-level model predicts every output
// beat (data, sof, cycle) and every frame_err pulse; a monitor compares as they appear.
module tb_fft_out_reorder;

  localparam int DW    = 30;
  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int BEATS = N / 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_l0, in_l1, in_l2, in_l3;
  logic          out_valid;
  logic          out_sof;
  logic [DW-1:0] out_l0, out_l1, out_l2, out_l3;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int              due;
    logic            sof;
    logic [4*DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            exp_err_q[$];
  logic [DW-1:0] frame_words[$];
  bit            filling = 1'b0;
  exp_t          mon_e;
  int            mon_err_due;

  fft_out_reorder #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_l0     (in_l0),
    .in_l1     (in_l1),
    .in_l2     (in_l2),
    .in_l3     (in_l3),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_l0    (out_l0),
    .out_l1    (out_l1),
    .out_l2    (out_l2),
    .out_l3    (out_l3),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: value seen at a negedge equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Natural bin b holds the sample that arrived at the bit-reversed position of b.
  function automatic int arrival_of_bin(input int bin);
    int k;
    k = 0;
    for (int i = 0; i < LOG2N; i++) if (((bin >> i) & 1) != 0) k += 1 << (LOG2N - 1 - i);
    return k;
  endfunction

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Drive one cycle of input and update the frame model.
  task automatic apply_stimulus(input logic v, input logic s,
                                input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    logic [DW-1:0] w [4];
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_l0    = w0;
    in_l1    = w1;
    in_l2    = w2;
    in_l3    = w3;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    if (v && rst) begin
      if (s) begin
        if (filling) exp_err_q.push_back(cyc + 1);
        frame_words.delete();
        filling = 1'b1;
      end
      if (filling) begin
        for (int l = 0; l < 4; l++) frame_words.push_back(w[l]);
        if (frame_words.size() == N) begin
          for (int r = 0; r < BEATS; r++) begin
            e.due  = cyc + 2 + r;
            e.sof  = (r == 0);
            e.data = '0;
            for (int l = 0; l < 4; l++) e.data[l*DW +: DW] = frame_words[arrival_of_bin(4*r + l)];
            exp_q.push_back(e);
          end
          frame_words.delete();
          filling = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  // One complete frame; word = base + arrival index unless random data is requested.
  task automatic drive_frame(input int base, input int gap_pct, input bit rand_data);
    for (int c = 0; c < BEATS; c++) begin
      while (int'($urandom_range(0, 99)) < gap_pct)
        apply_stimulus(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      if (rand_data)
        apply_stimulus(1'b1, c == 0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      else
        apply_stimulus(1'b1, c == 0, DW'(base + 4*c), DW'(base + 4*c + 1), DW'(base + 4*c + 2), DW'(base + 4*c + 3));
    end
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || exp_err_q.size() != 0) && budget < 200) begin
      idle_cycle();
      budget++;
    end
    checks++;
    if (exp_q.size() != 0 || exp_err_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain pending_beats=%0d pending_errs=%0d required 0", name, exp_q.size(), exp_err_q.size());
      exp_q.delete();
      exp_err_q.delete();
    end
    repeat (3) idle_cycle();
  endtask

  // Monitor: every presented beat and every frame_err pulse must match the next prediction.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat cycle=%0d sof=%0b data=%0h required no output", cyc, out_sof, {out_l3, out_l2, out_l1, out_l0});
        end else begin
          mon_e = exp_q.pop_front();
          check_output("beat_cycle", 128'(cyc), 128'(mon_e.due));
          check_output("beat_sof", 128'(out_sof), 128'(mon_e.sof));
          check_output("beat_data", 128'({out_l3, out_l2, out_l1, out_l0}), 128'(mon_e.data));
        end
      end else if (out_sof) begin
        checks++;
        errors++;
        $display("[TB] FAIL sof_without_valid actual=1 required=0");
      end
      if (frame_err) begin
        if (exp_err_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame_err cycle=%0d required no pulse", cyc);
        end else begin
          mon_err_due = exp_err_q.pop_front();
          check_output("frame_err_cycle", 128'(cyc), 128'(mon_err_due));
        end
      end
    end
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_l0    = '0;
    in_l1    = '0;
    in_l2    = '0;
    in_l3    = '0;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_out_valid", 128'(out_valid), 128'(0));
    check_output("reset_out_sof", 128'(out_sof), 128'(0));
    check_output("reset_out_data", 128'({out_l3, out_l2, out_l1, out_l0}), 128'(0));
    check_output("reset_frame_err", 128'(frame_err), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) idle_cycle();

    $display("[TB] single frame, word = arrival index");
    drive_frame(0, 0, 1'b0);
    wait_drain("single");

    $display("[TB] three back-to-back frames");
    for (int f = 0; f < 3; f++) drive_frame(100 * f, 0, 1'b0);
    wait_drain("back_to_back");

    $display("[TB] gapped frame");
    drive_frame(0, 50, 1'b0);
    wait_drain("gapped");

    $display("[TB] mid-fill sof restarts the frame");
    for (int c = 0; c < 5; c++)
      apply_stimulus(1'b1, c == 0, DW'(500 + 4*c), DW'(501 + 4*c), DW'(502 + 4*c), DW'(503 + 4*c));
    drive_frame(700, 0, 1'b0);
    wait_drain("mid_fill");

    $display("[TB] stray beats while idle");
    repeat (5) apply_stimulus(1'b1, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    wait_drain("stray");

    $display("[TB] randomized frames with gaps, strays and aborted partials");
    for (int i = 0; i < 8; i++) begin
      int partial;
      if ($urandom_range(0, 2) == 0)
        apply_stimulus(1'b1, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      partial = (i % 3 == 1) ? int'($urandom_range(1, BEATS - 1)) : 0;
      for (int c = 0; c < partial; c++)
        apply_stimulus(1'b1, c == 0, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      drive_frame(0, int'($urandom_range(0, 60)), 1'b1);
    end
    wait_drain("random");

    $display("[TB] reset in the middle of a drain");
    drive_frame(300, 0, 1'b0);
    repeat (3) idle_cycle();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("midreset_out_valid", 128'(out_valid), 128'(0));
    check_output("midreset_out_sof", 128'(out_sof), 128'(0));
    check_output("midreset_out_data", 128'({out_l3, out_l2, out_l1, out_l0}), 128'(0));
    check_output("midreset_frame_err", 128'(frame_err), 128'(0));
    exp_q.delete();
    exp_err_q.delete();
    frame_words.delete();
    filling = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) idle_cycle();
    drive_frame(900, 0, 1'b0);
    wait_drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
